bcd_stopwatch_ctrl: RTL and testbench

//  Run/pause/clear controller that sequences a chain of NDIG cascaded BCD decade counters from mclk.

---
 rtl/bcd_sw_pkg.sv | 28 ++
 rtl/bcd_stopwatch_ctrl_digit.sv | 20 ++
 rtl/bcd_stopwatch_ctrl.sv | 154 +++++++++++++++
 tb/tb_bcd_stopwatch_ctrl.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_sw_pkg.sv
// Shared encodings for the BCD stopwatch controller: FSM states and the
// active-low 7-segment patterns {g,f,e,d,c,b,a}.
package bcd_sw_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_PAUSE = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        RUN   = ST_RUN,
        PAUSE = ST_PAUSE
    } sw_state_t;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [6:0] SEG_LUT [0:9] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
    };

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        if (d > 4'd9)
            return SEG_BLANK;
        return SEG_LUT[d];
    endfunction

endpackage

// File: rtl/bcd_stopwatch_ctrl_digit.sv
// One BCD decade counter; co is combinational so a chain ripples in one cycle.
module bcd_digit (
    input  logic       mclk,
    input  logic       rst,
    input  logic       clr,
    input  logic       en,
    output logic [3:0] q,
    output logic       co
);

    always_ff @(posedge mclk) begin
        if (rst || clr)
            q <= 4'd0;
        else if (en)
            q <= (q == 4'd9) ? 4'd0 : q + 4'd1;
    end

    assign co = en & (q == 4'd9);

endmodule

// File: rtl/bcd_stopwatch_ctrl.sv
// Run/pause/clear stopwatch controller with multiplexed active-low 7-segment output.
// Optional lap display freeze is built when LAP_HOLD_EN is defined.
module bcd_stopwatch_ctrl
    import bcd_sw_pkg::*;
#(
    parameter int TICK_DIV = 100000,
    parameter int SCAN_DIV = 1000,
    parameter int NDIG     = 4
) (
    input  logic              mclk,
    input  logic              rst,
    input  logic              start_stop,
    input  logic              clear,
`ifdef LAP_HOLD_EN
    input  logic              lap,
`endif
    output logic              running,
    output logic [4*NDIG-1:0] cnt,
    output logic              ovf,
    output logic [NDIG-1:0]   an,
    output logic [6:0]        seg
);

    localparam int TW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int SW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = $clog2(NDIG);

    sw_state_t       state_q, state_d;
    logic            ss_prev;
    logic            ss_edge;
    logic [TW-1:0]   tick_cnt;
    logic            tick;
    logic [NDIG:0]   en_chain;
    logic [SW-1:0]   scan_cnt;
    logic [IW-1:0]   idx_p0;
    logic [4*NDIG-1:0] disp;
    logic [3:0]      disp_dig [NDIG];

    // Control: edge detect and FSM
    assign ss_edge = start_stop & ~ss_prev;

    always_ff @(posedge mclk) begin
        if (rst) begin
            state_q <= IDLE;
            ss_prev <= 1'b0;
        end else begin
            state_q <= state_d;
            ss_prev <= start_stop;
        end
    end

    always_comb begin
        state_d = state_q;
        running = (state_q == RUN);
        if (clear) begin
            state_d = IDLE;
        end else if (ss_edge) begin
            case (state_q)
                IDLE:    state_d = RUN;
                RUN:     state_d = PAUSE;
                PAUSE:   state_d = RUN;
                default: state_d = IDLE;
            endcase
        end
    end

    // Count tick: phase is held through PAUSE so a resume continues mid-period
    always_ff @(posedge mclk) begin
        if (rst || clear || state_q == IDLE)
            tick_cnt <= '0;
        else if (state_q == RUN)
            tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
    end

    assign tick = (state_q == RUN) && (tick_cnt == TW'(TICK_DIV - 1));

    // Decade chain
    assign en_chain[0] = tick;

    for (genvar gi = 0; gi < NDIG; gi++) begin : g_digit
        bcd_digit u_digit (
            .mclk (mclk),
            .rst  (rst),
            .clr  (clear),
            .en   (en_chain[gi]),
            .q    (cnt[4*gi +: 4]),
            .co   (en_chain[gi+1])
        );
        assign disp_dig[gi] = disp[4*gi +: 4];
    end

    always_ff @(posedge mclk) begin
        if (rst || clear)
            ovf <= 1'b0;
        else if (en_chain[NDIG])
            ovf <= 1'b1;
    end

`ifdef LAP_HOLD_EN
    logic              lap_prev;
    logic              freeze;
    logic              lap_edge;
    logic [4*NDIG-1:0] snap;

    assign lap_edge = lap & ~lap_prev & (state_q != IDLE) & ~clear;

    always_ff @(posedge mclk) begin
        if (rst) begin
            lap_prev <= 1'b0;
            freeze   <= 1'b0;
        end else begin
            lap_prev <= lap;
            if (clear)
                freeze <= 1'b0;
            else if (lap_edge)
                freeze <= ~freeze;
        end
    end

    always_ff @(posedge mclk) begin
        if (lap_edge && !freeze)
            snap <= cnt;
    end

    assign disp = (freeze && state_q != IDLE) ? snap : cnt;
`else
    assign disp = cnt;
`endif

    // Scan stage p0: free-running slot counter and digit index
    always_ff @(posedge mclk) begin
        if (rst) begin
            scan_cnt <= '0;
            idx_p0   <= '0;
        end else if (scan_cnt == SW'(SCAN_DIV - 1)) begin
            scan_cnt <= '0;
            idx_p0   <= (idx_p0 == IW'(NDIG - 1)) ? '0 : idx_p0 + 1'b1;
        end else begin
            scan_cnt <= scan_cnt + 1'b1;
        end
    end

    // Scan stage p1: registered anode select and segment pattern
    always_ff @(posedge mclk) begin
        if (rst) begin
            an  <= ~NDIG'(1);
            seg <= SEG_LUT[0];
        end else begin
            an  <= ~(NDIG'(1) << idx_p0);
            seg <= seg_decode(disp_dig[idx_p0]);
        end
    end

endmodule

// File: tb/tb_bcd_stopwatch_ctrl.sv
// Self-checking bench for bcd_stopwatch_ctrl (NDIG=4 main instance, NDIG=2 overflow instance).
module tb_bcd_stopwatch_ctrl;

    localparam int TICK_DIV = 4;
    localparam int SCAN_DIV = 2;
    localparam int NDIG     = 4;

    logic        mclk = 1'b0;
    logic        rst = 1'b1, start_stop = 1'b0, clear = 1'b0;
    logic        running, ovf;
    logic [15:0] cnt;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        ss2 = 1'b0, clr2 = 1'b0;
    logic        running2, ovf2;
    logic [7:0]  cnt2;
    logic [1:0]  an2;
    logic [6:0]  seg2;
`ifdef LAP_HOLD_EN
    logic        lap = 1'b0;
`endif

    always #5 mclk = ~mclk;

    bcd_stopwatch_ctrl #(.TICK_DIV(TICK_DIV), .SCAN_DIV(SCAN_DIV), .NDIG(NDIG)) u_dut (
        .mclk(mclk), .rst(rst), .start_stop(start_stop), .clear(clear),
`ifdef LAP_HOLD_EN
        .lap(lap),
`endif
        .running(running), .cnt(cnt), .ovf(ovf), .an(an), .seg(seg)
    );

    bcd_stopwatch_ctrl #(.TICK_DIV(TICK_DIV), .SCAN_DIV(SCAN_DIV), .NDIG(2)) u_dut2 (
        .mclk(mclk), .rst(rst), .start_stop(ss2), .clear(clr2),
`ifdef LAP_HOLD_EN
        .lap(1'b0),
`endif
        .running(running2), .cnt(cnt2), .ovf(ovf2), .an(an2), .seg(seg2)
    );

    typedef struct {
        logic        ss;
        logic        clr;
        int          n;
        logic        exp_run;
        logic [15:0] exp_cnt;
        logic        exp_ovf;
    } vec_t;

    typedef struct {
        string       name;
        logic [10:0] exp;
    } scan_exp_t;

    vec_t      tbl [16];
    vec_t      vec_q [$];
    scan_exp_t scan_q [$];
    int        checks = 0;
    int        errors = 0;
    int        cyc;

    function automatic logic [6:0] seg_ref(input logic [3:0] d);
        case (d)
            4'd0: return 7'b1000000;
            4'd1: return 7'b1111001;
            4'd2: return 7'b0100100;
            4'd3: return 7'b0110000;
            4'd4: return 7'b0011001;
            4'd5: return 7'b0010010;
            4'd6: return 7'b0000010;
            4'd7: return 7'b1111000;
            4'd8: return 7'b0000000;
            4'd9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        r = {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge mclk);
        #1;
        cyc += n;
    endtask

    // Wait (bounded) until an enters 1110 from another value.
    task automatic sync_scan(input string name);
        logic [3:0] prev;
        bit         found;
        prev  = an;
        found = 1'b0;
        for (int i = 0; i < 16 && !found; i++) begin
            step(1);
            if (an == 4'b1110 && prev != 4'b1110)
                found = 1'b1;
            prev = an;
        end
        if (!found) begin
            checks++;
            errors++;
            $display("FAIL %s_sync actual=no_digit0_slot required=digit0_slot_within_16", name);
        end
    endtask

    // Push expected scan sequence for a displayed value, then compare cycle by cycle.
    task automatic check_scan(input string name, input logic [15:0] shown);
        scan_exp_t e;
        for (int k = 0; k < 4; k++) begin
            for (int r = 0; r < 2; r++) begin
                e.name = $sformatf("%s_d%0d_%0d", name, k, r);
                e.exp  = {~(4'b0001 << k), seg_ref(shown[4*k +: 4])};
                scan_q.push_back(e);
            end
        end
        sync_scan(name);
        for (int k = 0; k < 8; k++) begin
            e = scan_q.pop_front();
            chk(e.name, {21'd0, an, seg}, {21'd0, e.exp});
            if (k < 7)
                step(1);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        //            ss    clr   n    run   cnt        ovf
        tbl[0]  = '{1'b1, 1'b0,   1, 1'b1, 16'h0000, 1'b0};  // start
        tbl[1]  = '{1'b1, 1'b0,  40, 1'b1, 16'h0010, 1'b0};  // 10 ticks
        tbl[2]  = '{1'b0, 1'b0,   1, 1'b1, 16'h0010, 1'b0};
        tbl[3]  = '{1'b1, 1'b0,   1, 1'b0, 16'h0010, 1'b0};  // pause, phase 2
        tbl[4]  = '{1'b1, 1'b0, 100, 1'b0, 16'h0010, 1'b0};  // frozen
        tbl[5]  = '{1'b0, 1'b0,   1, 1'b0, 16'h0010, 1'b0};
        tbl[6]  = '{1'b1, 1'b0,   1, 1'b1, 16'h0010, 1'b0};  // resume
        tbl[7]  = '{1'b1, 1'b0,   1, 1'b1, 16'h0010, 1'b0};
        tbl[8]  = '{1'b1, 1'b0,   1, 1'b1, 16'h0011, 1'b0};  // remaining 2 cycles
        tbl[9]  = '{1'b0, 1'b0,   1, 1'b1, 16'h0011, 1'b0};
        tbl[10] = '{1'b1, 1'b1,   1, 1'b0, 16'h0000, 1'b0};  // clear beats edge
        tbl[11] = '{1'b1, 1'b0,   3, 1'b0, 16'h0000, 1'b0};  // held level no edge
        tbl[12] = '{1'b0, 1'b0,   1, 1'b0, 16'h0000, 1'b0};
        tbl[13] = '{1'b1, 1'b0,   1, 1'b1, 16'h0000, 1'b0};
        tbl[14] = '{1'b0, 1'b0,   3, 1'b1, 16'h0000, 1'b0};
        tbl[15] = '{1'b1, 1'b0,   1, 1'b0, 16'h0001, 1'b0};  // tick with pause edge
        cyc = 0;

        step(1);
        rst = 1'b0;
        chk("rst_cnt", 32'(cnt), 32'h0);
        chk("rst_ovf", 32'(ovf), 32'h0);
        chk("rst_running", 32'(running), 32'h0);
        chk("rst_an", 32'(an), 32'hE);
        chk("rst_seg", 32'(seg), 32'h40);

        for (int i = 0; i < 16; i++) begin
            start_stop = tbl[i].ss;
            clear      = tbl[i].clr;
            vec_q.push_back(tbl[i]);
            step(tbl[i].n);
            v = vec_q.pop_front();
            chk($sformatf("vec%0d_running", i), 32'(running), 32'(v.exp_run));
            chk($sformatf("vec%0d_cnt", i), 32'(cnt), 32'(v.exp_cnt));
            chk($sformatf("vec%0d_ovf", i), 32'(ovf), 32'(v.exp_ovf));
        end

        // Reach 1234 exactly on a pausing edge, then check the scan sequence
        clear = 1'b1; start_stop = 1'b0;
        step(1);
        clear = 1'b0; start_stop = 1'b1;
        step(1);
        start_stop = 1'b0;
        step(4 * 1234 - 1);
        start_stop = 1'b1;
        step(1);
        chk("paused_1234_cnt", 32'(cnt), 32'h1234);
        chk("paused_1234_running", 32'(running), 32'h0);
        check_scan("scan1234", 16'h1234);
        chk("scan1234_cnt_held", 32'(cnt), 32'h1234);

        // Two-digit wrap and sticky overflow
        ss2 = 1'b1;
        step(1);
        chk("d2_running", 32'(running2), 32'h1);
        step(396);
        chk("d2_99_cnt", 32'(cnt2), 32'h99);
        chk("d2_99_ovf", 32'(ovf2), 32'h0);
        step(4);
        chk("d2_wrap_cnt", 32'(cnt2), 32'h00);
        chk("d2_wrap_ovf", 32'(ovf2), 32'h1);
        step(4);
        chk("d2_sticky_cnt", 32'(cnt2), 32'h01);
        chk("d2_sticky_ovf", 32'(ovf2), 32'h1);
        clr2 = 1'b1;
        step(1);
        clr2 = 1'b0;
        chk("d2_clear_cnt", 32'(cnt2), 32'h00);
        chk("d2_clear_ovf", 32'(ovf2), 32'h0);
        chk("d2_clear_running", 32'(running2), 32'h0);

        // Resume, then reset mid-run
        start_stop = 1'b0;
        step(1);
        start_stop = 1'b1;
        step(1);
        step(5);
        chk("resume_cnt", 32'(cnt), 32'h1235);
        chk("resume_running", 32'(running), 32'h1);
        rst = 1'b1; start_stop = 1'b0;
        step(1);
        rst = 1'b0;
        chk("midrst_cnt", 32'(cnt), 32'h0);
        chk("midrst_running", 32'(running), 32'h0);
        chk("midrst_ovf", 32'(ovf), 32'h0);
        chk("midrst_an", 32'(an), 32'hE);
        chk("midrst_seg", 32'(seg), 32'h40);
        step(3);
        chk("midrst_idle_cnt", 32'(cnt), 32'h0);

`ifdef LAP_HOLD_EN
        start_stop = 1'b1;
        step(1);
        cyc = 0;
        start_stop = 1'b0;
        step(20);
        chk("lap_pre_cnt", 32'(cnt), 32'h0005);
        lap = 1'b1;
        step(1);
        check_scan("lap0005", 16'h0005);
        chk("lap_live_cnt", 32'(cnt), 32'(to_bcd(cyc / TICK_DIV)));
        chk("lap_live_running", 32'(running), 32'h1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
